// File: rtl/vlan_stream_decoder.sv
// vlan_stream_decoder
//   Receive-path Ethernet header decoder. It parses destination MAC,
//   source MAC, up to MAX_VLAN stacked VLAN tags and the EtherType from a
//   32-bit big-endian beat stream. The payload is re-emitted realigned to
//   beat boundaries. Frames beyond MTU are truncated and the rest of the
//   frame is dropped. Runt frames are flagged, and the accepted frame length
//   is reported.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     input stream (byte 0 on [31:24])
//   in_last/in_keep               end of frame, byte enables of the last beat
//   out_data/out_valid/out_ready  realigned payload stream
//   out_last/out_keep             same encoding as the input
//   dest_addr, src_addr           MAC addresses
//   vlan_tag0, vlan_tag1          outer / inner tag as {TPID, TCI}
//   vlan_count                    tags consumed in the current frame
//   eth_type                      EtherType / length field
//   hdr_valid                     pulse: header outputs are valid
//   frame_len, len_valid          accepted byte count, pulse at frame end
//   err_runt, err_oversize        error pulses
module vlan_stream_decoder #(
    parameter int          MTU      = 1522,
    parameter int          MAX_VLAN = 2,
    parameter logic [15:0] TPID_S   = 16'h88A8,
    parameter logic [15:0] TPID_C   = 16'h8100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [3:0]  in_keep,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [3:0]  out_keep,
    output logic [47:0] dest_addr,
    output logic [47:0] src_addr,
    output logic [31:0] vlan_tag0,
    output logic [31:0] vlan_tag1,
    output logic [1:0]  vlan_count,
    output logic [15:0] eth_type,
    output logic        hdr_valid,
    output logic [15:0] frame_len,
    output logic        len_valid,
    output logic        err_runt,
    output logic        err_oversize
);

    localparam logic [15:0] MTU_W      = 16'(MTU);
    localparam logic [1:0]  MAX_VLAN_W = 2'(MAX_VLAN);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_FLUSH, S_DROP} state_t;

    state_t      state;
    logic [1:0]  hdr_beat;       // 0..2 fixed MAC beats, 3 = tag/type stage
    logic [15:0] byte_cnt;
    logic [15:0] residue;        // two payload bytes carried to the next beat
    logic [15:0] flush_data;
    logic [3:0]  flush_keep;
    logic        drop_pending;   // the pending FLUSH ends an oversize frame

    logic        accept;
    logic        out_free;
    logic [2:0]  beat_bytes;
    logic [15:0] cnt_base;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_next;
    logic        is_tpid;
    logic        tag_room;
    logic        oversize;

    assign out_free = !out_valid || out_ready;
    assign in_ready = rst && (state != S_FLUSH) && out_free;
    assign accept   = in_valid && in_ready;

    // Valid bytes in the current beat; only the last beat may be partial.
    always_comb begin
        beat_bytes = 3'd4;
        if (in_last) begin
            case (in_keep)
                4'b1000: beat_bytes = 3'd1;
                4'b1100: beat_bytes = 3'd2;
                4'b1110: beat_bytes = 3'd3;
                default: beat_bytes = 3'd4;
            endcase
        end
    end

    // Byte count including the current beat; beat0 restarts the count.
    assign cnt_base = (state == S_HDR && hdr_beat == 2'd0) ? 16'd0 : byte_cnt;
    assign cnt_sum  = {1'b0, cnt_base} + {14'd0, beat_bytes};
    assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    assign is_tpid  = (in_data[31:16] == TPID_S) || (in_data[31:16] == TPID_C);
    assign tag_room = vlan_count < MAX_VLAN_W;
    assign oversize = !in_last && (cnt_next >= MTU_W);

    // Parser state, header capture, the output register and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_HDR;
            hdr_beat     <= 2'd0;
            byte_cnt     <= 16'd0;
            residue      <= 16'd0;
            flush_data   <= 16'd0;
            flush_keep   <= 4'd0;
            drop_pending <= 1'b0;
            out_data     <= 32'd0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_keep     <= 4'd0;
            dest_addr    <= 48'd0;
            src_addr     <= 48'd0;
            vlan_tag0    <= 32'd0;
            vlan_tag1    <= 32'd0;
            vlan_count   <= 2'd0;
            eth_type     <= 16'd0;
            hdr_valid    <= 1'b0;
            frame_len    <= 16'd0;
            len_valid    <= 1'b0;
            err_runt     <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            hdr_valid    <= 1'b0;
            len_valid    <= 1'b0;
            err_runt     <= 1'b0;
            err_oversize <= 1'b0;
            // A consumed beat empties the register unless a new one loads below.
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                S_HDR: begin
                    if (accept) begin
                        byte_cnt <= cnt_next;
                        case (hdr_beat)
                            2'd0: begin
                                dest_addr[47:16] <= in_data;
                                vlan_count       <= 2'd0;
                                vlan_tag0        <= 32'd0;
                                vlan_tag1        <= 32'd0;
                            end
                            2'd1: begin
                                dest_addr[15:0]  <= in_data[31:16];
                                src_addr[47:32]  <= in_data[15:0];
                            end
                            2'd2: src_addr[31:0] <= in_data;
                            default: ;
                        endcase
                        if (hdr_beat != 2'd3) hdr_beat <= hdr_beat + 2'd1;

                        if (hdr_beat != 2'd3) begin
                            if (in_last) begin
                                err_runt  <= 1'b1;
                                frame_len <= cnt_next;
                                len_valid <= 1'b1;
                                hdr_beat  <= 2'd0;
                            end
                        end else if (in_last && in_keep == 4'b1000) begin
                            // Only one byte of the type field arrived.
                            err_runt  <= 1'b1;
                            frame_len <= cnt_next;
                            len_valid <= 1'b1;
                            hdr_beat  <= 2'd0;
                        end else if (is_tpid && tag_room) begin
                            if (vlan_count == 2'd0) vlan_tag0 <= in_data;
                            else                    vlan_tag1 <= in_data;
                            vlan_count <= vlan_count + 2'd1;
                            if (in_last) begin
                                err_runt  <= 1'b1;
                                frame_len <= cnt_next;
                                len_valid <= 1'b1;
                                hdr_beat  <= 2'd0;
                            end
                        end else begin
                            eth_type  <= in_data[31:16];
                            residue   <= in_data[15:0];
                            hdr_valid <= 1'b1;
                            hdr_beat  <= 2'd0;
                            if (in_last) begin
                                // Payload (if any) lives entirely in the type beat.
                                frame_len <= cnt_next;
                                len_valid <= 1'b1;
                                if (in_keep == 4'b1111) begin
                                    out_valid <= 1'b1;
                                    out_data  <= {in_data[15:0], 16'h0};
                                    out_keep  <= 4'b1100;
                                    out_last  <= 1'b1;
                                end else if (in_keep == 4'b1110) begin
                                    out_valid <= 1'b1;
                                    out_data  <= {in_data[15:8], 24'h0};
                                    out_keep  <= 4'b1000;
                                    out_last  <= 1'b1;
                                end
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (accept) begin
                        byte_cnt  <= cnt_next;
                        residue   <= in_data[15:0];
                        out_valid <= 1'b1;
                        out_data  <= {residue, in_data[31:16]};
                        out_keep  <= 4'b1111;
                        out_last  <= 1'b0;
                        if (in_last) begin
                            frame_len <= cnt_next;
                            len_valid <= 1'b1;
                            if (beat_bytes <= 3'd2) begin
                                out_keep <= (beat_bytes == 3'd1) ? 4'b1110 : 4'b1111;
                                out_last <= 1'b1;
                                state    <= S_HDR;
                            end else begin
                                flush_data   <= in_data[15:0];
                                flush_keep   <= (beat_bytes == 3'd3) ? 4'b1000 : 4'b1100;
                                drop_pending <= 1'b0;
                                state        <= S_FLUSH;
                            end
                        end else if (oversize) begin
                            // Close the payload as if this were a full last beat.
                            flush_data   <= in_data[15:0];
                            flush_keep   <= 4'b1100;
                            drop_pending <= 1'b1;
                            err_oversize <= 1'b1;
                            state        <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= {flush_data, 16'h0};
                        out_keep  <= flush_keep;
                        out_last  <= 1'b1;
                        state     <= drop_pending ? S_DROP : S_HDR;
                    end
                end

                S_DROP: begin
                    // Length excludes dropped beats, so report it on the way out.
                    if (accept && in_last) begin
                        frame_len <= byte_cnt;
                        len_valid <= 1'b1;
                        state     <= S_HDR;
                    end
                end

                default: state <= S_HDR;
            endcase
        end
    end

endmodule
